// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, reset PC, FSM state encoding and the buffered
// fetch entry type for the instruction fetch front end.
package ifetch_pkg;

  localparam int                          IFETCH_ADDR_W   = 32;
  localparam int                          IFETCH_DATA_W   = 32;
  localparam logic [IFETCH_ADDR_W-1:0]    IFETCH_RESET_PC = 32'h0000_0000;
  localparam int                          INSTR_BYTES     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [IFETCH_ADDR_W-1:0] pc;
    logic [IFETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: flushable in-order buffer of fetched {pc, instr} entries.
// A pop frees room for a same-cycle push, so push+pop works when full.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
  end

  // Pointer and occupancy state; flush empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign empty    = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: in-order instruction fetch with redirect flush/drop.
// Define IFETCH_BYPASS_EN to forward a response to decode in its arrival cycle.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = IFETCH_ADDR_W,
  parameter int                DATA_W   = IFETCH_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = IFETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [ADDR_W-1:0] dec_npc
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] rsp_pc_r;
  logic [ADDR_W-1:0] redirect_aligned_s;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  outstanding_next_s;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [CNT_W-1:0]  drop_cnt_next_s;
  logic [CNT_W-1:0]  occupancy_s;
  logic              credit_ok_s;
  logic              req_valid_s;
  logic              req_fire_s;
  logic              rsp_keep_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic              dec_valid_s;
  fetch_entry_t      push_entry_s;
  fetch_entry_t      head_entry_s;
  fetch_entry_t      out_entry_s;
`ifdef IFETCH_BYPASS_EN
  logic              bypass_s;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next state: DRAIN only while stale responses remain to be dropped.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = FETCH;
      FETCH: begin
        if (redirect_valid && (outstanding_next_s != {CNT_W{1'b0}})) state_next_s = DRAIN;
        else                                                           state_next_s = FETCH;
      end
      DRAIN: begin
        if (drop_cnt_next_s == {CNT_W{1'b0}}) state_next_s = FETCH;
        else                                  state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output: same-cycle dequeues are not credited, so the limit is conservative.
  always_comb begin
    credit_ok_s = ({1'b0, occupancy_s} + {1'b0, outstanding_r}) < (CNT_W + 1)'(DEPTH);
    case (state_r)
      FETCH:   req_valid_s = credit_ok_s && !redirect_valid;
      default: req_valid_s = 1'b0;
    endcase
  end

  // Request/response bookkeeping; a response in a redirect cycle is itself stale.
  always_comb begin
    redirect_aligned_s = redirect_pc & ~(ADDR_W'(INSTR_BYTES - 1));
    req_fire_s         = req_valid_s && imem_req_ready;
    rsp_keep_s         = imem_rsp_valid && (drop_cnt_r == {CNT_W{1'b0}}) && !redirect_valid;
    outstanding_next_s = outstanding_r + CNT_W'(req_fire_s) - CNT_W'(imem_rsp_valid);
    if (redirect_valid)                                            drop_cnt_next_s = outstanding_next_s;
    else if (imem_rsp_valid && (drop_cnt_r != {CNT_W{1'b0}}))      drop_cnt_next_s = drop_cnt_r - CNT_W'(1);
    else                                                           drop_cnt_next_s = drop_cnt_r;
    push_entry_s.pc    = rsp_pc_r;
    push_entry_s.instr = imem_rsp_data;
    pop_s              = !fifo_empty_s && dec_ready;
`ifdef IFETCH_BYPASS_EN
    bypass_s = rsp_keep_s && fifo_empty_s;
    push_s   = rsp_keep_s && !(bypass_s && dec_ready);
`else
    push_s   = rsp_keep_s;
`endif
  end

  // Fetch PC, response PC and in-flight counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= {CNT_W{1'b0}};
      drop_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= drop_cnt_next_s;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_aligned_s;
        rsp_pc_r   <= redirect_aligned_s;
      end else begin
        if (req_fire_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
        if (rsp_keep_s) rsp_pc_r   <= rsp_pc_r + PC_STEP;
      end
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_entry_s),
    .count     (occupancy_s),
    .empty     (fifo_empty_s)
  );

  // Decode-side view; fields read zero whenever nothing valid is offered.
  always_comb begin
    out_entry_s = head_entry_s;
    dec_valid_s = !fifo_empty_s;
`ifdef IFETCH_BYPASS_EN
    if (fifo_empty_s) begin
      out_entry_s = push_entry_s;
      dec_valid_s = bypass_s;
    end else begin
      out_entry_s = head_entry_s;
      dec_valid_s = 1'b1;
    end
`endif
    if (dec_valid_s) begin
      dec_instr = out_entry_s.instr;
      dec_pc    = out_entry_s.pc;
      dec_npc   = out_entry_s.pc + PC_STEP;
    end else begin
      dec_instr = {DATA_W{1'b0}};
      dec_pc    = {ADDR_W{1'b0}};
      dec_npc   = {ADDR_W{1'b0}};
    end
  end

  assign dec_valid      = dec_valid_s;
  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit with a fixed-latency memory
// model; expected {pc, instr} are queued per accepted request, popped at decode.
module tb_ifetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
  localparam int FIRST_DEC_LAT = 1;
`else
  localparam int FIRST_DEC_LAT = 2;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          dec_valid;
  logic          dec_ready;
  logic [DW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;
  logic [AW-1:0] dec_npc;

  ifetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_npc        (dec_npc)
  );

  always #5 clk = ~clk;

  int          cyc       = 0;
  int          lat       = 1;
  int          pass_cnt  = 0;
  int          check_cnt = 0;
  int          dec_cnt   = 0;
  int          rel_cyc   = 0;
  logic [31:0] wrap_npc  = 32'hDEAD_BEEF;
  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  mem_req_t    m;
  logic [31:0] e;
  logic [31:0] e_npc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    else return 32'hDEAD_BEEF;
  endfunction

  // Memory model: responds in order, lat cycles after acceptance.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hA000_0000 | mem_q[0].addr;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
    end
  end

  // Monitor: log requests, score decode handshakes, retire stale expectations on redirect.
  always @(negedge clk) begin
    if (!reset) begin
      mem_q.delete();
      exp_q.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        m.addr = imem_req_addr;
        m.due  = cyc + lat;
        mem_q.push_back(m);
        exp_q.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
      end
      if (dec_valid && dec_ready) begin
        dec_cnt++;
        check_eq("dec_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e     = exp_q.pop_front();
          e_npc = e + 32'd4;
          check_eq("dec_pc", dec_pc, e);
          check_eq("dec_instr", dec_instr, 32'hA000_0000 | e);
          check_eq("dec_npc", dec_npc, e_npc);
          if (dec_pc == 32'hFFFF_FFFC) wrap_npc = dec_npc;
        end
      end
      if (redirect_valid) exp_q.delete();
    end
  end

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_log.delete();
    dec_cnt = 0;
    reset   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_reqs(input int n);
    for (int i = 0; i < 100 && req_log.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("req_count_reached", 64'(req_log.size() >= n), 64'd1);
  endtask

  task automatic first_req_after_reset(input string tag);
    int first_req;
    first_req = -1;
    for (int i = 0; i < 20 && first_req < 0; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) first_req = cyc;
    end
    check_eq({tag, "_req_delay"}, 64'(first_req - rel_cyc), 64'd1);
    check_eq({tag, "_req_addr"}, imem_req_addr, 32'h0000_0000);
  endtask

  initial begin
    int first_req;
    int first_dec;
    int c0;
    int idx;
    logic [31:0] seen_pc;
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_req_valid", imem_req_valid, 1'b0);
    check_eq("rst_dec_valid", dec_valid, 1'b0);
    check_eq("rst_dec_instr", dec_instr, 32'h0);
    check_eq("rst_dec_pc", dec_pc, 32'h0);
    check_eq("rst_dec_npc", dec_npc, 32'h0);

    // Streaming fetch with single-cycle memory.
    lat = 1;
    do_reset();
    first_req = -1;
    for (int i = 0; i < 20 && first_req < 0; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) first_req = cyc;
    end
    check_eq("first_req_delay", 64'(first_req - rel_cyc), 64'd1);
    check_eq("first_req_addr", imem_req_addr, 32'h0);
    first_dec = -1;
    for (int i = 0; i < 20 && first_dec < 0; i++) begin
      @(negedge clk);
      if (dec_valid) first_dec = cyc;
    end
    check_eq("first_dec_latency", 64'(first_dec - first_req), 64'(FIRST_DEC_LAT));
    check_eq("first_dec_pc", dec_pc, 32'h0);
    check_eq("first_dec_npc", dec_npc, 32'h4);
    check_eq("first_dec_instr", dec_instr, 32'hA000_0000);
    @(posedge clk);
    #1;
    c0 = dec_cnt;
    repeat (10) @(posedge clk);
    #1;
    check_eq("throughput", 64'(dec_cnt - c0), 64'd10);
    check_eq("req_addr_1", req_at(1), 32'h4);
    check_eq("req_addr_2", req_at(2), 32'h8);

    // Decode stall: requests capped at DEPTH, then drain in order.
    dec_ready = 1'b0;
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    check_eq("stall_req_count", 64'(req_log.size()), 64'd4);
    check_eq("stall_req_first", req_at(0), 32'h0);
    check_eq("stall_req_last", req_at(3), 32'hC);
    check_eq("stall_req_valid_low", imem_req_valid, 1'b0);
    check_eq("stall_dec_valid", dec_valid, 1'b1);
    check_eq("stall_dec_pc_held", dec_pc, 32'h0);
    dec_ready = 1'b1;
    wait_reqs(5);
    check_eq("resume_addr", req_at(4), 32'h10);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat       = 3;
    dec_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && req_log.size() < 2; i++) begin
      @(posedge clk);
      #1;
    end
    idx = req_log.size();
    check_eq("inflight_before_redirect", 64'(idx), 64'd2);
    do_redirect(32'h0000_0100);
    @(negedge clk);
    check_eq("drain_state", 64'(dut.state_r), 64'(ifetch_pkg::DRAIN));
    check_eq("drain_dec_valid", dec_valid, 1'b0);
    wait_reqs(idx + 1);
    check_eq("redirect_req_addr", req_at(idx), 32'h100);
    seen_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 30 && seen_pc == 32'hDEAD_BEEF; i++) begin
      @(negedge clk);
      if (dec_valid) seen_pc = dec_pc;
    end
    check_eq("redirect_first_dec_pc", seen_pc, 32'h100);

    // Unaligned target and address wrap.
    lat = 1;
    repeat (4) @(posedge clk);
    #1;
    idx = req_log.size();
    do_redirect(32'h0000_0103);
    wait_reqs(idx + 1);
    check_eq("unaligned_redirect_addr", req_at(idx), 32'h100);
    repeat (3) @(posedge clk);
    #1;
    idx = req_log.size();
    do_redirect(32'hFFFF_FFF8);
    wait_reqs(idx + 3);
    check_eq("wrap_addr_0", req_at(idx), 32'hFFFF_FFF8);
    check_eq("wrap_addr_1", req_at(idx + 1), 32'hFFFF_FFFC);
    check_eq("wrap_addr_2", req_at(idx + 2), 32'h0000_0000);
    repeat (4) @(posedge clk);
    #1;
    check_eq("wrap_dec_npc", wrap_npc, 32'h0000_0000);

    // Asynchronous reset with buffered and in-flight work.
    dec_ready = 1'b0;
    lat       = 3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_reset_dec_valid", dec_valid, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_dec_valid", dec_valid, 1'b0);
    check_eq("async_rst_req_valid", imem_req_valid, 1'b0);
    dec_ready = 1'b1;
    lat       = 1;
    do_reset();
    first_req_after_reset("post_reset");
    repeat (8) @(posedge clk);
    #1;
    check_eq("post_reset_decodes", 64'(dec_cnt > 0), 64'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch front end and consumer of the PC/NPC pair. It issues in-order word fetch requests to instruction memory, buffers returned instructions with their PC, and hands them to decode over a valid/ready handshake. It handles redirects (branch, jump or trap) by flushing buffered instructions and dropping in-flight stale responses.

Parameters:
ADDR_W, 32, address/PC width
DATA_W, 32, instruction width
DEPTH, 4, instruction buffer entries (power of 2, >=2); also caps requests in flight
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order; no backpressure
imem_rsp_data  in  DATA_W  fetched instruction
redirect_valid  in  1  redirect request, 1-cycle pulse
redirect_pc  in  ADDR_W  redirect target
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode accepts
dec_instr  out  DATA_W  instruction
dec_pc  out  ADDR_W  PC of dec_instr
dec_npc  out  ADDR_W  dec_pc + 4

Behaviour:
- Reset (reset=0): state=IDLE, fetch_pc=RESET_PC, buffer empty, outstanding=0, drop_cnt=0. imem_req_valid=0, dec_valid=0. dec_instr, dec_pc and dec_npc read 0.
- FSM states:
  - IDLE -> FETCH on the first clock after reset releases.
  - FETCH -> DRAIN on redirect_valid when stale responses are in flight.
  - DRAIN -> FETCH when drop_cnt reaches 0.
  - FETCH stays FETCH on a redirect with nothing stale in flight.
- imem_req_valid = (state==FETCH) && (occupancy + outstanding < DEPTH) && !redirect_valid.
  - Same-cycle dequeues are not credited; the limit is deliberately conservative.
- Request handshake (valid && ready): outstanding += 1, fetch_pc += 4. Addition is mod 2^ADDR_W, so 0xFFFF_FFFC wraps to 0.
- Response:
  - drop_cnt > 0: discard the response, drop_cnt -= 1.
  - Otherwise: push {pc, instr} into the buffer.
  - In both cases outstanding -= 1.
  - Response PC comes from a response-PC register that advances by 4 per accepted response and is reloaded on redirect.
- Minimum latency: request accepted at cycle N; response at N+1 at the earliest; dec_valid at N+2 (without bypass).
- Redirect (highest priority):
  - Buffer flushed; dec_valid=0 on the next cycle.
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - drop_cnt = outstanding, counting a request accepted and/or a response arriving in the same cycle (a same-cycle response is itself dropped).
  - No request is issued in the redirect cycle.
- A redirect arriving during DRAIN restarts drop_cnt from the current outstanding count and uses the new target.
- Dequeue: dec_valid && dec_ready pops the buffer. Push and pop in the same cycle are allowed, including when the buffer is full.
- dec_valid is never asserted for a stale instruction. Output fields are stable while dec_valid && !dec_ready.
- Reset mid-operation: all state is cleared asynchronously. Responses from before the reset are the memory model's responsibility to suppress.

Optional Feature:
IFETCH_BYPASS_EN
- Defined: when the buffer is empty, drop_cnt==0 and no redirect is active, an arriving response drives dec_* combinationally in the same cycle.
  - If dec_ready=1, the instruction is consumed without a push.
  - Otherwise it is pushed.
  - Fetch-to-decode latency drops by one cycle.
- Undefined: all responses go through the buffer and dec_* come from registered buffer outputs only.

Decomposition:
- Package ifetch_pkg:
  - ADDR_W/DATA_W defaults
  - RESET_PC
  - INSTR_BYTES=4
  - state enum {IDLE, FETCH, DRAIN}
  - packed struct fetch_entry_t {pc, instr}
- Sub-module ifetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries, with flush input and occupancy count output, reset asynchronously. All other logic stays in ifetch_unit.

Test Plan:
- Reset release, imem always ready, 1-cycle responses with instr = 0xA000_0000|addr -> req addrs 0,4,8,…; first dec_valid 2 cycles after the first request, with dec_pc=0, dec_npc=4, dec_instr=0xA000_0000; one instruction per cycle thereafter.
- dec_ready=0 for 12 cycles, DEPTH=4 -> exactly 4 requests accepted (0x0–0xC), then req_valid held low; on dec_ready=1, 4 instructions drain in order 0x0,0x4,0x8,0xC and fetch resumes at 0x10.
- Memory latency 3, two requests in flight, redirect_pc=0x100 -> two stale responses produce no dec_valid; FSM in DRAIN; next request addr 0x100; first dec_pc=0x100.
- redirect_pc=0x103 -> req addr 0x100. Redirect at 0xFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; dec_npc for FFFF_FFFC is 0.
- Assert reset with a full buffer and requests in flight -> dec_valid=0 and req_valid=0 immediately (asynchronously); after release, the first request is at addr 0 one cycle later.
- With IFETCH_BYPASS_EN, buffer empty, response at cycle N -> dec_valid at cycle N with the matching PC. Without it, dec_valid at N+1.
